// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame stages: receiver FSM states and line levels.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register for received words; flags an overrun when a
// completed word arrives while an unconsumed word is still held.
module rx_out_buf #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_take;

  // A load is allowed when empty or when the held word is drained this same cycle.
  assign w_take = i_load & (~r_valid | i_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= i_load & r_valid & ~i_ready;
      if (w_take) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid & i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB-first, optional even parity, stop bit.
// Define PARITY_RX_EN to expect a parity bit between the last data bit and the stop bit.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned     CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err;
  logic              w_stop_smp;
  logic              w_par_ok;
  logic              w_good;
  logic              w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (bit_en) begin
      unique case (r_state)
        IDLE:   if (s_in == START_LVL) w_next_state = DATA;
`ifdef PARITY_RX_EN
        DATA:   if (r_cnt == LAST) w_next_state = PARITY;
`else
        DATA:   if (r_cnt == LAST) w_next_state = STOP;
`endif
        PARITY: w_next_state = STOP;
        STOP:   w_next_state = IDLE;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

`ifdef PARITY_RX_EN
  logic r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              r_par <= 1'b0;
    else if (bit_en && r_state == PARITY) r_par <= s_in;
  end

  // Even parity: data bits plus the parity bit must contain an even number of ones.
  assign w_par_ok = ~(^{r_shift, r_par});
`else
  assign w_par_ok = 1'b1;
`endif

  // New bits enter at the MSB so the first data bit ends up in bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_shift     <= {DATA_W{IDLE_LVL}};
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_stop_smp & ~w_good;
      if (bit_en) begin
        if (r_state == IDLE && s_in == START_LVL) begin
          r_cnt <= '0;
        end else if (r_state == DATA) begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_shift <= {s_in, r_shift[DATA_W-1:1]};
        end
      end
    end
  end

  assign w_stop_smp = bit_en & (r_state == STOP);
  assign w_good     = (s_in == STOP_LVL) & w_par_ok;
  assign w_load     = w_stop_smp & w_good;
  assign frame_err  = r_frame_err;

  rx_out_buf #(
    .DATA_W(DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_data    (r_shift),
    .i_ready   (out_ready),
    .o_data    (out_data),
    .o_valid   (out_valid),
    .o_overrun (overrun)
  );

endmodule
